// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetches over a ready handshake, decodes the
// LDUR/STUR/ADD/SUB/AND/ORR/CBZ/B subset from a private IR and steps the datapath controls.
module multicycle_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_instruction,
  input  logic               i_imem_ready,
  input  logic               i_dmem_ready,
  output logic               o_imem_req,
  output logic               o_dmem_req,
  output logic               o_ir_write,
  output logic               o_pc_write,
  output logic               o_reg2loc,
  output logic               o_uncond_branch,
  output logic               o_branch,
  output logic               o_mem_read,
  output logic               o_mem_reg,
  output logic               o_mem_write,
  output logic               o_alu_src,
  output logic               o_reg_write,
  output logic [3:0]         o_alu_op,
  output logic [2:0]         o_state,
  output logic               o_illegal,
  output logic [COUNT_W-1:0] o_instr_count
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_LDUR = 4'd0, I_STUR = 4'd1, I_ADD = 4'd2, I_SUB = 4'd3, I_AND = 4'd4,
    I_ORR = 4'd5, I_CBZ = 4'd6, I_B = 4'd7, I_ILL = 4'd8
  } instr_t;

  function automatic instr_t decode_op(input logic [10:0] opc);
    instr_t op;
    if (opc == 11'b11111000010)      op = I_LDUR;
    else if (opc == 11'b11111000000) op = I_STUR;
    else if (opc == 11'b10001011000) op = I_ADD;
    else if (opc == 11'b11001011000) op = I_SUB;
    else if (opc == 11'b10001010000) op = I_AND;
    else if (opc == 11'b10101010000) op = I_ORR;
    else if (opc[10:3] == 8'b10110100) op = I_CBZ;
    else if (opc[10:5] == 6'b000101)   op = I_B;
    else op = I_ILL;
    return op;
  endfunction

  function automatic logic [3:0] alu_op_of(input instr_t op);
    logic [3:0] f;
    case (op)
      I_LDUR, I_STUR, I_ADD: f = 4'b0010;
      I_SUB:                 f = 4'b0110;
      I_AND:                 f = 4'b0000;
      I_ORR:                 f = 4'b0001;
      I_CBZ:                 f = 4'b0111;
      default:               f = 4'b0000;
    endcase
    return f;
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_ir;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;
  instr_t             w_op;
  logic               w_unused_ir;

  logic w_imem_req, w_dmem_req, w_ir_write, w_pc_write, w_reg2loc, w_uncond, w_branch;
  logic w_mem_read, w_mem_reg, w_mem_write, w_alu_src, w_reg_write, w_set_illegal;
  logic [3:0] w_alu_op;

  assign w_op        = decode_op(r_ir[31:21]);
  assign w_unused_ir = ^r_ir[20:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IR, sticky illegal flag and retired-instruction counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ir      <= 32'd0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_ir_write)    r_ir      <= i_instruction;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_pc_write)    r_count   <= r_count + COUNT_W'(1);
    end
  end

  // Next-state and Moore controls; only ir_write, pc_write and the MEMORY exit see ready
  always_comb begin
    w_next_state  = r_state;
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg2loc     = 1'b0;
    w_uncond      = 1'b0;
    w_branch      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_reg     = 1'b0;
    w_mem_write   = 1'b0;
    w_alu_src     = 1'b0;
    w_reg_write   = 1'b0;
    w_set_illegal = 1'b0;
    w_alu_op      = 4'b0000;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_ready) begin
          w_ir_write   = 1'b1;
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        w_reg2loc = (w_op == I_STUR) || (w_op == I_CBZ);
        if (w_op == I_ILL) begin
          w_set_illegal = 1'b1;
          w_next_state  = S_HALT;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_reg2loc = (w_op == I_STUR) || (w_op == I_CBZ);
        w_alu_op  = alu_op_of(w_op);
        w_alu_src = (w_op == I_LDUR) || (w_op == I_STUR);
        case (w_op)
          I_LDUR, I_STUR:             w_next_state = S_MEMORY;
          I_ADD, I_SUB, I_AND, I_ORR: w_next_state = S_WRITEBACK;
          I_CBZ: begin
            w_branch     = 1'b1;
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
          end
          I_B: begin
            w_uncond     = 1'b1;
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_HALT;
        endcase
      end
      S_MEMORY: begin
        w_reg2loc   = (w_op == I_STUR);
        w_alu_op    = alu_op_of(w_op);
        w_alu_src   = 1'b1;
        w_dmem_req  = 1'b1;
        w_mem_read  = (w_op == I_LDUR);
        w_mem_write = (w_op == I_STUR);
        if (i_dmem_ready) begin
          if (w_op == I_LDUR) begin
            w_next_state = S_WRITEBACK;
          end else begin
            w_pc_write   = 1'b1;
            w_next_state = S_FETCH;
          end
        end else begin
          w_next_state = S_MEMORY;
        end
      end
      S_WRITEBACK: begin
        w_alu_op     = alu_op_of(w_op);
        w_alu_src    = (w_op == I_LDUR);
        w_reg_write  = 1'b1;
        w_mem_reg    = (w_op == I_LDUR);
        w_pc_write   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Controls are forced low while reset is held, so a reset mid-access cannot retire it
  assign o_imem_req      = w_imem_req  & ~i_rst;
  assign o_dmem_req      = w_dmem_req  & ~i_rst;
  assign o_ir_write      = w_ir_write  & ~i_rst;
  assign o_pc_write      = w_pc_write  & ~i_rst;
  assign o_reg2loc       = w_reg2loc   & ~i_rst;
  assign o_uncond_branch = w_uncond    & ~i_rst;
  assign o_branch        = w_branch    & ~i_rst;
  assign o_mem_read      = w_mem_read  & ~i_rst;
  assign o_mem_reg       = w_mem_reg   & ~i_rst;
  assign o_mem_write     = w_mem_write & ~i_rst;
  assign o_alu_src       = w_alu_src   & ~i_rst;
  assign o_reg_write     = w_reg_write & ~i_rst;
  assign o_alu_op        = w_alu_op & {4{~i_rst}};
  assign o_illegal       = r_illegal   & ~i_rst;
  assign o_state         = r_state;
  assign o_instr_count   = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-instruction cycle timelines built from
// the instruction class and wait counts, compared every cycle against the DUT outputs.
module tb_multicycle_sequencer;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, imem_ready, dmem_ready;
  logic [31:0]   instruction;
  logic          imem_req, dmem_req, ir_write, pc_write, reg2loc, uncond, branch;
  logic          mem_read, mem_reg, mem_write, alu_src, reg_write, illegal;
  logic [3:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_sequencer #(.COUNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_instruction(instruction),
    .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
    .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_reg2loc(reg2loc), .o_uncond_branch(uncond),
    .o_branch(branch), .o_mem_read(mem_read), .o_mem_reg(mem_reg),
    .o_mem_write(mem_write), .o_alu_src(alu_src), .o_reg_write(reg_write),
    .o_alu_op(alu_op), .o_state(state), .o_illegal(illegal), .o_instr_count(instr_count)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          imem_req, dmem_req, ir_write, pc_write, reg2loc, uncond, branch;
    logic          mem_read, mem_reg, mem_write, alu_src, reg_write;
    logic [3:0]    aluop;
    logic          illegal;
    logic [CW-1:0] cnt;
  } obs_t;

  localparam int K_LDUR = 0, K_STUR = 1, K_ADD = 2, K_SUB = 3;
  localparam int K_AND = 4, K_ORR = 5, K_CBZ = 6, K_B = 7, K_ILL = 8;

  obs_t        q_exp[$];
  logic        q_imr[$], q_dmr[$], q_rst[$];
  logic [31:0] q_ins[$];
  string       q_tag[$];
  logic [CW-1:0] m_cnt = '0;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] make_instr(int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_LDUR: r[31:21] = 11'b11111000010;
      K_STUR: r[31:21] = 11'b11111000000;
      K_ADD:  r[31:21] = 11'b10001011000;
      K_SUB:  r[31:21] = 11'b11001011000;
      K_AND:  r[31:21] = 11'b10001010000;
      K_ORR:  r[31:21] = 11'b10101010000;
      K_CBZ:  r[31:24] = 8'b10110100;
      K_B:    r[31:26] = 6'b000101;
      default: r[31:26] = 6'b000000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] alu_of(int k);
    case (k)
      K_LDUR, K_STUR, K_ADD: return 4'b0010;
      K_SUB:                 return 4'b0110;
      K_ORR:                 return 4'b0001;
      K_CBZ:                 return 4'b0111;
      default:               return 4'b0000;
    endcase
  endfunction

  task automatic push(obs_t e, logic imr, logic dmr, logic [31:0] ins, logic r, string tag);
    q_exp.push_back(e);
    q_imr.push_back(imr);
    q_dmr.push_back(dmr);
    q_ins.push_back(ins);
    q_rst.push_back(r);
    q_tag.push_back(tag);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected timeline of one instruction; abort leaves it stalled in MEMORY.
  task automatic add_instr(int k, int fw, int dw, logic [31:0] ins, bit abort, string tag);
    obs_t e;
    logic is_mem;
    is_mem = (k == K_LDUR) || (k == K_STUR);
    for (int i = 0; i < fw; i++) begin
      e = '0; e.cnt = m_cnt; e.st = 3'd0; e.imem_req = 1'b1;
      push(e, 1'b0, rb(), $urandom, 1'b0, tag);
    end
    e = '0; e.cnt = m_cnt; e.st = 3'd0; e.imem_req = 1'b1; e.ir_write = 1'b1;
    push(e, 1'b1, rb(), ins, 1'b0, tag);
    e = '0; e.cnt = m_cnt; e.st = 3'd1; e.reg2loc = (k == K_STUR) || (k == K_CBZ);
    push(e, rb(), rb(), $urandom, 1'b0, tag);
    if (k == K_ILL) return;
    e.st = 3'd2; e.aluop = alu_of(k); e.alu_src = is_mem;
    e.branch = (k == K_CBZ); e.uncond = (k == K_B);
    e.pc_write = (k == K_CBZ) || (k == K_B);
    push(e, rb(), rb(), $urandom, 1'b0, tag);
    if (e.pc_write) begin m_cnt++; return; end
    e.branch = 1'b0; e.uncond = 1'b0;
    if (is_mem) begin
      e.st = 3'd3; e.dmem_req = 1'b1;
      e.mem_read = (k == K_LDUR); e.mem_write = (k == K_STUR);
      for (int i = 0; i < dw; i++) push(e, rb(), 1'b0, $urandom, 1'b0, tag);
      if (abort) return;
      e.pc_write = (k == K_STUR);
      push(e, rb(), 1'b1, $urandom, 1'b0, tag);
      if (e.pc_write) begin m_cnt++; return; end
    end
    e = '0; e.cnt = m_cnt; e.st = 3'd4; e.aluop = alu_of(k); e.alu_src = is_mem;
    e.reg_write = 1'b1; e.mem_reg = (k == K_LDUR); e.pc_write = 1'b1;
    push(e, rb(), rb(), $urandom, 1'b0, tag);
    m_cnt++;
  endtask

  task automatic add_halt(int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.cnt = m_cnt; e.st = 3'd5; e.illegal = 1'b1;
      push(e, rb(), rb(), $urandom, 1'b0, "halt");
    end
  endtask

  // Reset for n cycles; the first cycle still shows the pre-reset state and count.
  task automatic add_reset(logic [2:0] prev_st, int n);
    obs_t e;
    e = '0; e.st = prev_st; e.cnt = m_cnt;
    push(e, 1'b1, 1'b1, $urandom, 1'b1, "reset");
    m_cnt = '0;
    for (int i = 1; i < n; i++) begin
      e = '0;
      push(e, rb(), rb(), $urandom, 1'b1, "reset");
    end
  endtask

  task automatic run();
    obs_t got, e;
    string tag;
    while (q_exp.size() > 0) begin
      @(negedge clk);
      rst         = q_rst.pop_front();
      imem_ready  = q_imr.pop_front();
      dmem_ready  = q_dmr.pop_front();
      instruction = q_ins.pop_front();
      e   = q_exp.pop_front();
      tag = q_tag.pop_front();
      #1;
      got = '0;
      got.st = state; got.imem_req = imem_req; got.dmem_req = dmem_req;
      got.ir_write = ir_write; got.pc_write = pc_write; got.reg2loc = reg2loc;
      got.uncond = uncond; got.branch = branch; got.mem_read = mem_read;
      got.mem_reg = mem_reg; got.mem_write = mem_write; got.alu_src = alu_src;
      got.reg_write = reg_write; got.aluop = alu_op; got.illegal = illegal;
      got.cnt = instr_count;
      n_tests++;
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s @%0t: observed %b expected %b", tag, $time, got, e);
      end
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; instruction = 32'd0;
    @(posedge clk);
    add_reset(3'd0, 2);
    add_instr(K_STUR, 0, 0, 32'b11111000000_00000000011_00010_00001, 1'b0, "stur_zw");
    add_instr(K_LDUR, 0, 3, make_instr(K_LDUR), 1'b0, "ldur_wait");
    add_instr(K_ADD, 0, 0, make_instr(K_ADD), 1'b0, "add");
    add_instr(K_SUB, 0, 0, make_instr(K_SUB), 1'b0, "sub");
    add_instr(K_CBZ, 0, 0, make_instr(K_CBZ), 1'b0, "cbz");
    add_instr(K_B, 1, 0, make_instr(K_B), 1'b0, "b");
    add_instr(K_AND, 2, 0, make_instr(K_AND), 1'b0, "and");
    add_instr(K_ORR, 0, 0, make_instr(K_ORR), 1'b0, "orr");
    run();
    add_instr(K_ILL, 0, 0, 32'd0, 1'b0, "illegal");
    add_halt(12);
    add_reset(3'd5, 2);
    add_instr(K_STUR, 0, 3, make_instr(K_STUR), 1'b1, "stur_abort");
    add_reset(3'd3, 2);
    add_instr(K_B, 0, 0, make_instr(K_B), 1'b0, "after_rst");
    run();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      add_instr(k, $urandom_range(0, 2), $urandom_range(0, 2), make_instr(k), 1'b0, "random");
    end
    run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the LEGv8 datapath. It fetches one instruction at a time over a request/ready handshake and decodes the LDUR/STUR/ADD/SUB/AND/ORR/CBZ/B subset. It then steps through FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK, driving the datapath control lines only in the states where they are valid. It sits between the instruction/data memories and the register file/ALU, and can replace the single-cycle control decoder when memories have variable latency.

## Interface
- `COUNT_W`, default 16, width of the retired-instruction counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instruction`  in  32  instruction memory read data; valid when `imem_ready`=1.
- `imem_ready`  in  1  instruction memory has data this cycle.
- `dmem_ready`  in  1  data memory has completed the access this cycle.
- `imem_req`  out  1  fetch request.
- `dmem_req`  out  1  data memory request. Accompanied by `MemRead` or `MemWrite`.
- `ir_write`  out  1  one-cycle pulse; datapath latches the instruction.
- `pc_write`  out  1  one-cycle pulse; PC update. Target is chosen by `Branch`/`UncondBranch`.
- `Reg2Loc`, `UncondBranch`, `Branch`, `MemRead`, `MemReg`, `MemWrite`, `ALUscr`, `RegWrite`  out  1 each  datapath controls.
- `ALUop`  out  4  ALU function: AND 0000, ORR 0001, ADD 0010, SUB 0110, pass-B 0111.
- `state`  out  3  current state, for debug.
- `illegal`  out  1  sticky; an undecodable opcode was seen.
- `instr_count`  out  COUNT_W  number of retired instructions; wraps modulo 2^COUNT_W.

## Operation
- **Opcode decode:**
  - LDUR: [31:21]=11111000010
  - STUR: [31:21]=11111000000
  - ADD: [31:21]=10001011000
  - SUB: [31:21]=11001011000
  - AND: [31:21]=10001010000
  - ORR: [31:21]=10101010000
  - CBZ: [31:24]=10110100
  - B: [31:26]=000101
  - Anything else is illegal.
- **Internal IR:** loaded from `instruction` on `ir_write`. All decode works from the IR, never from the live `instruction` bus.
- **State encoding:** FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- **FETCH:**
  - `imem_req`=1.
  - On `imem_ready`=1: `ir_write`=1, go to DECODE. Otherwise stay.
- **DECODE:**
  - `Reg2Loc`=1 for STUR/CBZ.
  - Illegal opcode: set `illegal`, go to HALT.
  - Otherwise go to EXECUTE.
- **EXECUTE:**
  - `ALUop` per instruction: LDUR/STUR ADD, CBZ pass-B.
  - `ALUscr`=1 for LDUR/STUR.
  - R-type: go to WRITEBACK.
  - LDUR/STUR: go to MEMORY.
  - CBZ: `Branch`=1, `pc_write`=1, go to FETCH.
  - B: `UncondBranch`=1, `pc_write`=1, go to FETCH.
- **MEMORY:**
  - `dmem_req`=1 with `MemRead` (LDUR) or `MemWrite` (STUR), held until `dmem_ready`=1.
  - On completion, LDUR goes to WRITEBACK.
  - On completion, STUR pulses `pc_write` and goes to FETCH.
- **WRITEBACK:**
  - `RegWrite`=1, with `MemReg`=1 for LDUR.
  - `pc_write`=1, go to FETCH.
- **HALT:** all outputs 0 except `illegal`=1. Stays in HALT until `rst`.
- **Signal hold rules:**
  - `Reg2Loc`, `ALUop` and `ALUscr` hold their decoded value from DECODE (`Reg2Loc`) or EXECUTE (`ALUop`, `ALUscr`) until the instruction retires. They are 0 in FETCH.
  - `RegWrite`, `MemWrite`, `MemRead`, `pc_write` and `ir_write` are never asserted outside the states listed above.
- **Counter:** `instr_count` increments on every `pc_write` and wraps from all-ones to 0.

## Timing
- **Output style:** all outputs are Moore functions of the registered state and IR. The exceptions are `ir_write`, `pc_write` and the MEMORY exit, which are also qualified by `imem_ready`/`dmem_ready` in the same cycle.
- **Latency with zero-wait memories:**
  - CBZ/B: 3 cycles.
  - R-type and STUR: 4 cycles.
  - LDUR: 5 cycles.
  - Each wait cycle adds 1.
- **Ready handshakes:**
  - `imem_ready` is ignored outside FETCH.
  - `dmem_ready` is ignored outside MEMORY.
  - Ready in the same cycle the request first rises counts as completion.
- **Reset:**
  - When `rst`=1 at a clock edge: state=FETCH, IR=0, `illegal`=0, `instr_count`=0. All control outputs are 0 during reset.
  - `imem_req`=1 in the first cycle after `rst` falls.
  - Reset mid-MEMORY: `dmem_req`/`MemWrite` are 0 in the cycle after the reset edge, and no `pc_write` or count increment occurs.
- **Counter boundary:** at `instr_count`=2^COUNT_W−1, the next retire gives 0.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → all outputs 0, `state`=0, `instr_count`=0. Then `imem_req`=1 in the next cycle.
- **STUR, zero-wait:** `instruction`=11111000000_00000000011_00010_00001, `imem_ready`=`dmem_ready`=1 →
  - `Reg2Loc`=1 from DECODE.
  - EXECUTE: `ALUop`=0010, `ALUscr`=1.
  - MEMORY: `MemWrite`=`dmem_req`=`pc_write`=1.
  - `RegWrite` never 1; 4 cycles total; `instr_count`=1.
- **LDUR with wait states:** `dmem_ready` held low for 3 cycles → `MemRead`/`dmem_req` high for 4 cycles. Then WRITEBACK with `RegWrite`=`MemReg`=`pc_write`=1; 8 cycles total.
- **ADD then SUB, back to back:** `ALUop` 0010 then 0110. `RegWrite` is a single-cycle pulse per instruction, 4 cycles apart; `instr_count`=2.
- **Branches:**
  - CBZ: `Branch`=1, `ALUop`=0111, `Reg2Loc`=1, `pc_write` in cycle 3.
  - B: `UncondBranch`=1, `Branch`=0, 3 cycles.
- **Illegal opcode:** `instruction`=0 → HALT (`state`=5), `illegal`=1, `imem_req` stays 0 for 10+ cycles. `rst` clears it.
- **Reset mid-STUR:** `rst` asserted in MEMORY → `MemWrite`=0 in the following cycle, `instr_count` unchanged at 0.
